// File: rtl/tick_bcd_timer_pkg.sv
// Shared definitions for the mm:ss BCD timer: state encoding, digit limits
// and the packed-field layout of {m_tens, m_ones, s_tens, s_ones}.
package tick_bcd_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [3:0] BCD_ONES_MAX = 4'd9;
  localparam logic [3:0] BCD_TENS_MAX = 4'd5;

  localparam int DIGIT_W    = 4;
  localparam int S_ONES_LSB = 0;
  localparam int S_TENS_LSB = 4;
  localparam int M_ONES_LSB = 8;
  localparam int M_TENS_LSB = 12;

  function automatic logic [3:0] get_digit(input logic [15:0] v, input int lsb);
    return v[lsb +: DIGIT_W];
  endfunction

  function automatic logic [6:0] bcd2_to_bin(input logic [3:0] tens, input logic [3:0] ones);
    return ({3'b000, tens} * 7'd10) + {3'b000, ones};
  endfunction

endpackage

// File: rtl/tick_bcd_timer_digit.sv
// One BCD digit with its own wrap limit; carry/borrow ripple to the next
// digit in the same cycle so the whole chain updates on one edge.
module bcd_digit
  import tick_bcd_timer_pkg::*;
#(
  parameter logic [3:0] LIMIT = BCD_ONES_MAX
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       inc_i,
  input  logic       dec_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  output logic [3:0] digit_o,
  output logic       carry_o,
  output logic       borrow_o
);

  logic [3:0] digit_q;
  logic [3:0] digit_d;

  // Next digit value: load wins over counting
  always_comb begin
    digit_d = digit_q;
    if (load_i) begin
      digit_d = load_val_i;
    end else if (inc_i) begin
      digit_d = (digit_q >= LIMIT) ? 4'd0 : digit_q + 4'd1;
    end else if (dec_i) begin
      digit_d = (digit_q == 4'd0) ? LIMIT : digit_q - 4'd1;
    end else begin
      digit_d = digit_q;
    end
  end

  // Digit register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit_o  = digit_q;
  assign carry_o  = inc_i && (digit_q == LIMIT);
  assign borrow_o = dec_i && (digit_q == 4'd0);

endmodule

// File: rtl/tick_bcd_timer.sv
// mm:ss stopwatch / countdown timer in packed BCD, advanced by a one-cycle
// tick enable; control FSM and minute-limit checks live here.
module tick_bcd_timer
  import tick_bcd_timer_pkg::*;
#(
  parameter int MIN_MAX = 59
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tick,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        dir,
  output logic [15:0] bcd,
  output logic        running,
  output logic        done,
  output logic        wrap,
  output logic        load_err
);

  localparam logic [3:0]  MAX_TENS = 4'(MIN_MAX / 10);
  localparam logic [3:0]  MAX_ONES = 4'(MIN_MAX % 10);
  localparam logic [6:0]  MAX_MIN  = 7'(MIN_MAX);
  localparam logic [15:0] MAX_TIME = {MAX_TENS, MAX_ONES, BCD_TENS_MAX, BCD_ONES_MAX};

  state_e      state_q;
  logic        running_q, done_q, wrap_q, load_err_q;
  logic [15:0] time_s;
  logic [15:0] dig_load_val_s;
  logic [3:0]  inc_s, dec_s, carry_s, borrow_s;
  logic        count_s, up_s, dn_s, up_wrap_s, dn_wrap_s, dn_done_s;
  logic        lv_valid_s, load_ok_s, load_rej_s, dig_load_s, start_ok_s;

  assign count_s   = tick && (state_q == ST_RUN) && !clear && !load && !stop;
  assign up_s      = count_s && !dir;
  assign dn_s      = count_s && dir;
  assign up_wrap_s = up_s && (time_s == MAX_TIME);
  assign dn_done_s = dn_s && (time_s == 16'h0001);
  // Only reachable by reversing direction at 00:00 mid-run: roll back to the top
  assign dn_wrap_s = dn_s && (time_s == 16'h0000);

  assign lv_valid_s = (get_digit(load_val, M_TENS_LSB) <= BCD_ONES_MAX) &&
                      (get_digit(load_val, M_ONES_LSB) <= BCD_ONES_MAX) &&
                      (get_digit(load_val, S_TENS_LSB) <= BCD_TENS_MAX) &&
                      (get_digit(load_val, S_ONES_LSB) <= BCD_ONES_MAX) &&
                      (bcd2_to_bin(get_digit(load_val, M_TENS_LSB),
                                   get_digit(load_val, M_ONES_LSB)) <= MAX_MIN);
  assign load_ok_s  = load && !clear && (state_q != ST_RUN) && lv_valid_s;
  assign load_rej_s = load && !clear && !load_ok_s;
  assign start_ok_s = (state_q == ST_IDLE) || (state_q == ST_HOLD);
  assign dig_load_s = clear || load_ok_s || up_wrap_s || dn_wrap_s;

  // Value forced into all four digits when they do not simply count
  always_comb begin
    dig_load_val_s = 16'h0000;
    if (clear) begin
      dig_load_val_s = 16'h0000;
    end else if (load_ok_s) begin
      dig_load_val_s = load_val;
    end else if (dn_wrap_s) begin
      dig_load_val_s = MAX_TIME;
    end else begin
      dig_load_val_s = 16'h0000;
    end
  end

  assign inc_s = {carry_s[2:0], up_s};
  assign dec_s = {borrow_s[2:0], dn_s};

  for (genvar i = 0; i < 4; i++) begin : g_digit
    localparam logic [3:0] LIM = (i == 1) ? BCD_TENS_MAX : BCD_ONES_MAX;
    bcd_digit #(.LIMIT(LIM)) u_digit (
      .clk        (clk),
      .reset_n    (reset_n),
      .inc_i      (inc_s[i]),
      .dec_i      (dec_s[i]),
      .load_i     (dig_load_s),
      .load_val_i (dig_load_val_s[i*4 +: 4]),
      .digit_o    (time_s[i*4 +: 4]),
      .carry_o    (carry_s[i]),
      .borrow_o   (borrow_s[i])
    );
  end

  // Control FSM with registered status outputs; clear > load > stop > start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrap_q     <= up_wrap_s;
      load_err_q <= load_rej_s;
      if (clear || load_ok_s) begin
        state_q   <= ST_IDLE;
        running_q <= 1'b0;
        done_q    <= 1'b0;
      end else if (load) begin
        state_q <= state_q;
      end else if (stop) begin
        if (state_q == ST_RUN) begin
          state_q   <= ST_HOLD;
          running_q <= 1'b0;
        end
      end else if (start && start_ok_s) begin
        if (dir && (time_s == 16'h0000)) begin
          state_q   <= ST_DONE;
          running_q <= 1'b0;
          done_q    <= 1'b1;
        end else begin
          state_q   <= ST_RUN;
          running_q <= 1'b1;
        end
      end else if (dn_done_s) begin
        state_q   <= ST_DONE;
        running_q <= 1'b0;
        done_q    <= 1'b1;
      end else begin
        state_q <= state_q;
      end
    end
  end

  assign bcd      = time_s;
  assign running  = running_q;
  assign done     = done_q;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_tick_bcd_timer.sv
// Randomized and directed bench: two timers (MIN_MAX 59 and 9) share inputs and
// are compared every cycle against a seconds-based reference model.
module tb_tick_bcd_timer;

  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_HOLD = 2;
  localparam int S_DONE = 3;

  logic        clk, reset_n;
  logic        tick, start, stop, clear, load, dir;
  logic [15:0] load_val;
  logic [15:0] bcd_a, bcd_b;
  logic        run_a, run_b, done_a, done_b, wrap_a, wrap_b, lerr_a, lerr_b;

  int checks = 0;
  int errors = 0;

  int m_secs[2];
  int m_st[2];
  bit m_done[2];
  bit m_wrap[2];
  bit m_lerr[2];
  int maxm[2] = '{59, 9};

  tick_bcd_timer #(.MIN_MAX(59)) dut_a (
    .clk(clk), .reset_n(reset_n), .tick(tick), .start(start), .stop(stop),
    .clear(clear), .load(load), .load_val(load_val), .dir(dir),
    .bcd(bcd_a), .running(run_a), .done(done_a), .wrap(wrap_a), .load_err(lerr_a)
  );

  tick_bcd_timer #(.MIN_MAX(9)) dut_b (
    .clk(clk), .reset_n(reset_n), .tick(tick), .start(start), .stop(stop),
    .clear(clear), .load(load), .load_val(load_val), .dir(dir),
    .bcd(bcd_b), .running(run_b), .done(done_b), .wrap(wrap_b), .load_err(lerr_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int secs);
    int m, s;
    m = secs / 60;
    s = secs % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic bit lv_ok(input logic [15:0] lv, input int mx);
    int mt, mo, st, so;
    mt = int'(lv[15:12]); mo = int'(lv[11:8]); st = int'(lv[7:4]); so = int'(lv[3:0]);
    if (mt > 9 || mo > 9 || st > 5 || so > 9) return 1'b0;
    return (mt * 10 + mo) <= mx;
  endfunction

  function automatic int lv_secs(input logic [15:0] lv);
    return (int'(lv[15:12]) * 10 + int'(lv[11:8])) * 60 + int'(lv[7:4]) * 10 + int'(lv[3:0]);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_secs[k] = 0; m_st[k] = S_IDLE;
      m_done[k] = 1'b0; m_wrap[k] = 1'b0; m_lerr[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k);
    int top;
    top = maxm[k] * 60 + 59;
    m_wrap[k] = 1'b0;
    m_lerr[k] = 1'b0;
    if (clear) begin
      m_secs[k] = 0; m_st[k] = S_IDLE; m_done[k] = 1'b0;
    end else if (load) begin
      if (m_st[k] == S_RUN || !lv_ok(load_val, maxm[k])) begin
        m_lerr[k] = 1'b1;
      end else begin
        m_secs[k] = lv_secs(load_val); m_st[k] = S_IDLE; m_done[k] = 1'b0;
      end
    end else if (stop) begin
      if (m_st[k] == S_RUN) m_st[k] = S_HOLD;
    end else if (start && (m_st[k] == S_IDLE || m_st[k] == S_HOLD)) begin
      if (dir && m_secs[k] == 0) begin
        m_st[k] = S_DONE; m_done[k] = 1'b1;
      end else begin
        m_st[k] = S_RUN;
      end
    end else if (tick && m_st[k] == S_RUN) begin
      if (!dir) begin
        if (m_secs[k] == top) begin
          m_secs[k] = 0; m_wrap[k] = 1'b1;
        end else begin
          m_secs[k]++;
        end
      end else if (m_secs[k] == 0) begin
        m_secs[k] = top;
      end else begin
        m_secs[k]--;
        if (m_secs[k] == 0) begin
          m_st[k] = S_DONE; m_done[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all();
    check_val("bcd59",  bcd_a,       to_bcd(m_secs[0]));
    check_val("run59",  16'(run_a),  16'(m_st[0] == S_RUN));
    check_val("done59", 16'(done_a), 16'(m_done[0]));
    check_val("wrap59", 16'(wrap_a), 16'(m_wrap[0]));
    check_val("lerr59", 16'(lerr_a), 16'(m_lerr[0]));
    check_val("bcd9",   bcd_b,       to_bcd(m_secs[1]));
    check_val("run9",   16'(run_b),  16'(m_st[1] == S_RUN));
    check_val("done9",  16'(done_b), 16'(m_done[1]));
    check_val("wrap9",  16'(wrap_b), 16'(m_wrap[1]));
    check_val("lerr9",  16'(lerr_b), 16'(m_lerr[1]));
  endtask

  task automatic drive(input bit c, input bit l, input logic [15:0] lv,
                       input bit sp, input bit st, input bit tk, input bit d);
    clear = c; load = l; load_val = lv; stop = sp; start = st; tick = tk; dir = d;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare_all();
  endtask

  initial begin
    logic [15:0] exp_seq [3];
    logic [15:0] bad_lv [3];
    int m, s;
    exp_seq[0] = 16'h0959; exp_seq[1] = 16'h1000; exp_seq[2] = 16'h1001;
    bad_lv[0] = 16'h0A00; bad_lv[1] = 16'h0070; bad_lv[2] = 16'h6000;

    reset_n = 1'b0;
    tick = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0;
    dir = 1'b0; load_val = 16'h0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    reset_n = 1'b1;

    // up-count carries
    drive(0, 1, 16'h0958, 0, 0, 0, 0);
    drive(0, 0, 16'h0000, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 16'h0000, 0, 0, 1, 0);
      check_val("carry_bcd", bcd_a, exp_seq[i]);
      check_val("carry_run", 16'(run_a), 16'd1);
    end

    // up-count wrap at both limits
    drive(1, 0, 16'h0000, 0, 0, 0, 0);
    drive(0, 1, 16'h5959, 0, 0, 0, 0);
    check_val("lerr9_5959", 16'(lerr_b), 16'd1);
    drive(0, 0, 16'h0000, 0, 1, 0, 0);
    drive(0, 0, 16'h0000, 0, 0, 1, 0);
    check_val("wrap_bcd", bcd_a, 16'h0000);
    check_val("wrap_pulse", 16'(wrap_a), 16'd1);
    drive(0, 0, 16'h0000, 0, 0, 0, 0);
    check_val("wrap_one_cycle", 16'(wrap_a), 16'd0);
    check_val("wrap_run", 16'(run_a), 16'd1);
    drive(1, 0, 16'h0000, 0, 0, 0, 0);
    drive(0, 1, 16'h0959, 0, 0, 0, 0);
    drive(0, 0, 16'h0000, 0, 1, 0, 0);
    drive(0, 0, 16'h0000, 0, 0, 1, 0);
    check_val("wrap9_bcd", bcd_b, 16'h0000);
    check_val("wrap9_pulse", 16'(wrap_b), 16'd1);

    // count-down completion
    drive(1, 0, 16'h0000, 0, 0, 0, 1);
    drive(0, 1, 16'h0101, 0, 0, 0, 1);
    drive(0, 0, 16'h0000, 0, 1, 0, 1);
    for (int i = 0; i < 61; i++) drive(0, 0, 16'h0000, 0, 0, 1, 1);
    check_val("down_bcd", bcd_a, 16'h0000);
    check_val("down_done", 16'(done_a), 16'd1);
    check_val("down_run", 16'(run_a), 16'd0);
    repeat (3) drive(0, 0, 16'h0000, 0, 0, 1, 1);
    drive(0, 0, 16'h0000, 0, 1, 1, 1);
    check_val("done_start_ign", 16'(run_a), 16'd0);
    drive(1, 0, 16'h0000, 0, 0, 0, 1);
    check_val("clear_done", 16'(done_a), 16'd0);

    // invalid loads, then load while running
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, bad_lv[i], 0, 0, 0, 0);
      check_val("bad_lerr", 16'(lerr_a), 16'd1);
      check_val("bad_bcd", bcd_a, 16'h0000);
    end
    drive(0, 1, 16'h0012, 0, 0, 0, 0);
    drive(0, 0, 16'h0000, 0, 1, 0, 0);
    drive(0, 0, 16'h0000, 0, 0, 1, 0);
    drive(0, 1, 16'h1234, 0, 0, 1, 0);
    check_val("run_load_lerr", 16'(lerr_a), 16'd1);
    check_val("run_load_bcd", bcd_a, 16'h0013);
    drive(0, 0, 16'h0000, 0, 0, 1, 0);
    check_val("run_load_cont", bcd_a, 16'h0014);

    // same-cycle events
    drive(1, 0, 16'h0000, 0, 0, 0, 0);
    drive(0, 1, 16'h0003, 0, 0, 0, 0);
    drive(0, 0, 16'h0000, 0, 1, 0, 0);
    repeat (2) drive(0, 0, 16'h0000, 0, 0, 1, 0);
    drive(0, 0, 16'h0000, 1, 0, 1, 0);
    check_val("stop_tick_bcd", bcd_a, 16'h0005);
    check_val("stop_tick_run", 16'(run_a), 16'd0);
    drive(0, 1, 16'h0007, 0, 0, 0, 0);
    drive(0, 0, 16'h0000, 0, 1, 1, 0);
    check_val("start_tick_bcd", bcd_a, 16'h0007);
    drive(0, 0, 16'h0000, 0, 0, 1, 0);
    check_val("start_tick_next", bcd_a, 16'h0008);
    drive(1, 1, 16'h0042, 0, 1, 1, 0);
    check_val("clr_ld_st_bcd", bcd_a, 16'h0000);
    check_val("clr_ld_st_run", 16'(run_a), 16'd0);

    // asynchronous reset mid-run at 12:34
    drive(0, 1, 16'h1234, 0, 0, 0, 0);
    drive(0, 0, 16'h0000, 0, 1, 0, 0);
    drive(0, 0, 16'h0000, 0, 0, 0, 0);
    #3 reset_n = 1'b0;
    #1;
    model_reset();
    check_val("areset_bcd", bcd_a, 16'h0000);
    check_val("areset_run", 16'(run_a), 16'd0);
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    reset_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      bit c, l, sp, st, tk, d;
      logic [15:0] lv;
      c  = ($urandom_range(99) < 2);
      l  = ($urandom_range(99) < 6);
      sp = ($urandom_range(99) < 4);
      st = ($urandom_range(99) < 10);
      tk = ($urandom_range(99) < 60);
      d  = ($urandom_range(99) < 5) ? ~dir : dir;
      if ($urandom_range(3) == 0) begin
        lv = 16'($urandom);
      end else begin
        m = ($urandom_range(1) == 0) ? $urandom_range(1) : $urandom_range(59);
        s = $urandom_range(59);
        lv = to_bcd(m * 60 + s);
      end
      drive(c, l, lv, sp, st, tk, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tick_bcd_timer.md
Name: tick_bcd_timer

Overview:
- Downstream consumer of the prescaler's divided-rate output. Takes a 1-cycle tick enable synchronous to `clk` (nominally 1 Hz on DE10) and keeps an mm:ss time value in packed BCD.
- Supports count-up stopwatch mode and count-down timer mode, with start/stop/clear/load control.
- Feeds the 7-segment decode stage and the LED status logic.
- Everything runs on the single fast clock; the tick is used as a clock enable, never as a clock.

Parameters:
- MIN_MAX, 59, maximum minutes value (legal range 1..99); up-count wraps after MIN_MAX:59.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset; all state cleared on assertion
- tick  input  1  one-cycle count enable from the prescaler stage
- start  input  1  begin or resume counting
- stop  input  1  pause counting
- clear  input  1  zero the time and return to IDLE
- load  input  1  preset time from load_val
- load_val  input  16  packed BCD {m_tens, m_ones, s_tens, s_ones}
- dir  input  1  0 = count up, 1 = count down
- bcd  output  16  current time, packed BCD, same layout as load_val
- running  output  1  high while state is RUN
- done  output  1  count-down reached 00:00; level output
- wrap  output  1  one-cycle pulse on up-count rollover
- load_err  output  1  one-cycle pulse when a load is rejected

Behaviour:
- Reset: while reset_n = 0 (asynchronous), state = IDLE, bcd = 16'h0000, and running, done, wrap and load_err are all 0.
- States: IDLE, RUN, HOLD, DONE. running = (state == RUN).
- Command priority within one cycle: clear > load > stop > start. Lower-priority commands in the same cycle are ignored.
- clear, any state: bcd <= 0, state <= IDLE, done <= 0.
- load, accepted only in IDLE/HOLD/DONE:
  - bcd <= load_val, done <= 0, state <= IDLE.
  - Rejected (bcd unchanged, load_err pulses) if any of:
    - state is RUN;
    - any digit > 9;
    - s_tens > 5;
    - minutes value > MIN_MAX.
- stop: RUN -> HOLD. No effect in other states.
- start:
  - IDLE/HOLD -> RUN.
  - Ignored in DONE and RUN.
  - If dir = 1 and bcd = 0000, go IDLE/HOLD -> DONE with done = 1; no RUN cycle.
- Tick counting:
  - A tick is counted only if state is RUN in that cycle and no clear/load/stop is asserted.
  - A tick arriving in the same cycle as start is not counted; RUN takes effect next cycle.
  - Ticks in IDLE/HOLD/DONE are ignored.
- Latency: bcd updates on the clk edge that samples tick = 1, visible the next cycle. No internal tick buffering, so back-to-back ticks each count.
- Up count (dir = 0):
  - s_ones 9 -> 0 carries to s_tens; s_tens 5 -> 0 carries to m_ones; m_ones 9 -> 0 carries to m_tens.
  - At MIN_MAX:59, next tick gives 00:00 and wrap = 1 for exactly one cycle; state stays RUN.
- Down count (dir = 1):
  - Borrow chain is the mirror of up count (s 00 -> 59 with a minute borrow).
  - When the result is 00:00: state <= DONE, done <= 1 in the same edge, running drops.
  - done holds until clear or an accepted load.
- dir may change at any time and applies to the next counted tick.
- wrap and load_err are registered pulses, never longer than one cycle.

Decomposition:
- Shared package/include holds:
  - state encoding constants (IDLE = 0, RUN = 1, HOLD = 2, DONE = 3);
  - BCD limit constants (9, 5);
  - packed-field index macros for the m_tens/m_ones/s_tens/s_ones slices.
- Sub-module `bcd_digit` is instantiated 4 times:
  - parameter LIMIT (9 or 5);
  - inputs: inc, dec, load, load value;
  - outputs: digit, carry_out (at LIMIT on inc), borrow_out (at 0 on dec).
- Minute-limit compare and FSM live in the top module.

Test Plan:
- Reset: assert reset_n = 0 mid-RUN at 12:34 -> bcd = 0000, running = 0, done = 0 immediately, asynchronously.
- Up-count carries: load 0958, start, dir = 0, 3 ticks -> 0959, 1000, 1001; running = 1 throughout.
- Up-count wrap: load 5959, start, 1 tick -> bcd = 0000, wrap = 1 for one cycle, running stays 1. Repeat with MIN_MAX = 9: load 0959 -> 0000.
- Count-down completion: load 0101, dir = 1, start, 61 ticks -> bcd = 0000, done = 1, running = 0. Further ticks leave bcd = 0000; start is ignored; clear drops done.
- Invalid loads: in IDLE, load 0A00, then 0070, then 6000 -> load_err pulses each time, bcd unchanged. Load 1234 while RUN -> load_err = 1, count continues.
- Same-cycle events:
  - stop + tick in RUN at 0005 -> HOLD, bcd stays 0005.
  - start + tick from IDLE -> bcd unchanged that cycle, next tick counts.
  - clear + load + start together -> bcd = 0000, IDLE.
